// File: rtl/spi_mem_master_if.sv
`default_nettype none
// ============================================================================
// spi_mem_master_if : control handshake and SPI pins of the SPI memory master
// Rev 1.0
// ============================================================================
interface spi_mem_master_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
);
   logic              start;
   logic              rw;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] rdata;
   logic              sclk;
   logic              cs;
   logic              mosi;
   logic              miso;

   // master: on-chip controller plus the memory board; slave: the SPI initiator block
   modport master (
      output start, rw, addr, wdata, miso,
      input  busy, done, rdata, sclk, cs, mosi
   );

   modport slave (
      input  start, rw, addr, wdata, miso,
      output busy, done, rdata, sclk, cs, mosi
   );
endinterface
`default_nettype wire

// File: rtl/spi_mem_master.sv
`default_nettype none
// ============================================================================
// spi_mem_master : mode-0 SPI initiator for single-byte reads/writes of the lab SPI memory
// Rev 1.0
// ============================================================================
module spi_mem_master #(
   parameter int CLKDIV = 4,
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
) (
   input  wire logic       clk,
   input  wire logic       reset,
   spi_mem_master_if.slave bus
);
   localparam int c_frame_w = ADDR_W + 1 + DATA_W;
   localparam int c_hp_w    = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam int c_bit_w   = $clog2(c_frame_w + 1);
   localparam logic [c_hp_w-1:0]  c_hp_last = c_hp_w'(CLKDIV - 1);
   localparam logic [c_bit_w-1:0] c_bits    = c_bit_w'(c_frame_w);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      HOLD = 2'd3
   } state_t;

   state_t               r_state;
   logic [c_frame_w-1:0] r_frame;
   logic [DATA_W-1:0]    r_rx;
   logic [DATA_W-1:0]    r_rdata;
   logic [c_hp_w-1:0]    r_hp;
   logic [c_bit_w-1:0]   r_bits;
   logic                 r_rw;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_sclk;
   logic                 r_cs;
   logic                 r_mosi;
   logic                 w_hp_end;

   assign w_hp_end = (r_hp == c_hp_last);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_frame <= '0;
         r_rx    <= '0;
         r_rdata <= '0;
         r_hp    <= '0;
         r_bits  <= '0;
         r_rw    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sclk  <= 1'b0;
         r_cs    <= 1'b1;
         r_mosi  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_frame <= {bus.addr, bus.rw, bus.rw ? {DATA_W{1'b0}} : bus.wdata};
                  r_rw    <= bus.rw;
                  r_bits  <= c_bits;
                  r_hp    <= '0;
                  r_busy  <= 1'b1;
                  r_cs    <= 1'b0;
                  r_mosi  <= bus.addr[ADDR_W-1];
                  r_state <= LOW;
               end
            end
            LOW: begin
               if (w_hp_end) begin
                  r_hp    <= '0;
                  r_sclk  <= 1'b1;
                  r_state <= HIGH;
               end else begin
                  r_hp <= r_hp + 1'b1;
               end
            end
            HIGH: begin
               if (w_hp_end) begin
                  // miso has been stable since the previous falling edge
                  r_hp    <= '0;
                  r_sclk  <= 1'b0;
                  r_rx    <= {r_rx[DATA_W-2:0], bus.miso};
                  r_frame <= {r_frame[c_frame_w-2:0], 1'b0};
                  r_bits  <= r_bits - 1'b1;
                  if (r_bits == c_bit_w'(1)) begin
                     r_mosi  <= 1'b0;
                     r_state <= HOLD;
                  end else begin
                     r_mosi  <= r_frame[c_frame_w-2];
                     r_state <= LOW;
                  end
               end else begin
                  r_hp <= r_hp + 1'b1;
               end
            end
            HOLD: begin
               if (w_hp_end) begin
                  r_hp    <= '0;
                  r_busy  <= 1'b0;
                  r_cs    <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= IDLE;
                  if (r_rw) begin
                     r_rdata <= r_rx;
                  end
               end else begin
                  r_hp <= r_hp + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.busy  = r_busy;
   assign bus.done  = r_done;
   assign bus.rdata = r_rdata;
   assign bus.sclk  = r_sclk;
   assign bus.cs    = r_cs;
   assign bus.mosi  = r_mosi;
endmodule
`default_nettype wire

// File: tb/tb_spi_mem_master.sv
`default_nettype none
// ============================================================================
// tb_spi_mem_master : bench for spi_mem_master with a behavioural SPI memory model
// Rev 1.0
// ============================================================================
module tb_spi_mem_master;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sel = 1'b0;   // 0 selects the CLKDIV=4 unit, 1 the CLKDIV=1 unit
   logic       start = 1'b0;
   logic       rw = 1'b0;
   logic [6:0] addr = '0;
   logic [7:0] wdata = '0;
   logic       miso = 1'b0;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   spi_mem_master_if #(.ADDR_W(7), .DATA_W(8)) bus4 ();
   spi_mem_master_if #(.ADDR_W(7), .DATA_W(8)) bus1 ();

   assign bus4.start = start & ~sel;
   assign bus1.start = start & sel;
   assign bus4.rw    = rw;
   assign bus1.rw    = rw;
   assign bus4.addr  = addr;
   assign bus1.addr  = addr;
   assign bus4.wdata = wdata;
   assign bus1.wdata = wdata;
   assign bus4.miso  = miso;
   assign bus1.miso  = miso;

   spi_mem_master #(.CLKDIV(4), .ADDR_W(7), .DATA_W(8)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
   spi_mem_master #(.CLKDIV(1), .ADDR_W(7), .DATA_W(8)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

   logic       o_busy, o_done, o_sclk, o_cs, o_mosi;
   logic [7:0] o_rdata;
   assign o_busy  = sel ? bus1.busy  : bus4.busy;
   assign o_done  = sel ? bus1.done  : bus4.done;
   assign o_sclk  = sel ? bus1.sclk  : bus4.sclk;
   assign o_cs    = sel ? bus1.cs    : bus4.cs;
   assign o_mosi  = sel ? bus1.mosi  : bus4.mosi;
   assign o_rdata = sel ? bus1.rdata : bus4.rdata;

   // Behavioural SPI memory: samples mosi on sclk rise, drives miso after sclk fall.
   logic [7:0]  mem [0:127];
   logic [15:0] sh = '0;
   logic [15:0] last_frame = '0;
   logic [6:0]  s_addr = '0;
   logic        s_rw = 1'b0;
   logic        prev_sclk = 1'b0;
   logic        prev_cs = 1'b1;
   logic [7:0]  sb;
   int          cnt = 0;
   int          last_bits = 0;
   int          frames = 0;
   int          done_cnt = 0;
   logic [7:0]  exp_rd [0:1];

   always @(negedge clk) begin
      if (o_done === 1'b1) done_cnt++;
      if (o_cs === 1'b1 && prev_cs === 1'b0) begin
         last_frame = sh;
         last_bits  = cnt;
         frames++;
         if (cnt == 16 && !s_rw) mem[s_addr] = sh[7:0];
         cnt = 0;
         sh  = '0;
      end else if (o_cs === 1'b0) begin
         if (o_sclk === 1'b1 && prev_sclk === 1'b0) begin
            sh = {sh[14:0], o_mosi};
            cnt++;
            if (cnt == 8) begin
               s_addr = sh[7:1];
               s_rw   = sh[0];
            end
         end else if (o_sclk === 1'b0 && prev_sclk === 1'b1) begin
            if (cnt >= 8 && cnt < 16 && s_rw) begin
               sb   = mem[s_addr];
               miso = sb[15-cnt];
            end else begin
               miso = 1'($urandom);
            end
         end
      end
      prev_sclk = o_sclk;
      prev_cs   = o_cs;
   end

   // Drives one request and waits for done; lat is counted in cycles from the accept cycle.
   task automatic do_txn(input logic r, input logic [6:0] a, input logic [7:0] w,
                         output int lat, output logic [7:0] rd,
                         output logic b1, output logic c1, output logic s1, output logic m1);
      @(negedge clk);
      start = 1'b1; rw = r; addr = a; wdata = w;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      b1 = o_busy; c1 = o_cs; s1 = o_sclk; m1 = o_mosi;
      while (o_done !== 1'b1 && lat < 400) begin
         @(negedge clk);
         lat++;
      end
      if (o_done !== 1'b1) lat = -1;
      rd = o_rdata;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s);
         #1;
         total++; if (o_cs !== 1'b1)     begin bad++; $display("FAIL reset_cs[%0d]: got %b want 1", s, o_cs); end
         total++; if (o_sclk !== 1'b0)   begin bad++; $display("FAIL reset_sclk[%0d]: got %b want 0", s, o_sclk); end
         total++; if (o_mosi !== 1'b0)   begin bad++; $display("FAIL reset_mosi[%0d]: got %b want 0", s, o_mosi); end
         total++; if (o_busy !== 1'b0)   begin bad++; $display("FAIL reset_busy[%0d]: got %b want 0", s, o_busy); end
         total++; if (o_done !== 1'b0)   begin bad++; $display("FAIL reset_done[%0d]: got %b want 0", s, o_done); end
         total++; if (o_rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata[%0d]: got %h want 00", s, o_rdata); end
      end
      sel = 1'b0;
      reset = 1'b0;
      exp_rd[0] = 8'h00;
      exp_rd[1] = 8'h00;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_write_spec();
      int lat; logic [7:0] rd; logic b1, c1, s1, m1;
      sel = 1'b0;
      do_txn(1'b0, 7'h2A, 8'hA5, lat, rd, b1, c1, s1, m1);
      @(negedge clk);
      total++; if (lat !== 133)  begin bad++; $display("FAIL wr_latency: got %0d want 133", lat); end
      total++; if ({b1, c1, s1, m1} !== 4'b1000) begin bad++; $display("FAIL wr_first_cycle busy/cs/sclk/mosi: got %b want 1000", {b1, c1, s1, m1}); end
      total++; if (last_frame !== 16'h54A5 || last_bits != 16) begin bad++; $display("FAIL wr_frame: got %h/%0d want 54a5/16", last_frame, last_bits); end
      total++; if (rd !== 8'h00) begin bad++; $display("FAIL wr_rdata: got %h want 00", rd); end
   endtask

   task automatic test_read_spec();
      int lat; logic [7:0] rd; logic b1, c1, s1, m1;
      sel = 1'b0;
      mem[7'h2A] = 8'h3C;
      do_txn(1'b1, 7'h2A, 8'hFF, lat, rd, b1, c1, s1, m1);
      @(negedge clk);
      exp_rd[0] = 8'h3C;
      total++; if (lat !== 133)  begin bad++; $display("FAIL rd_latency: got %0d want 133", lat); end
      total++; if (last_frame !== 16'h5500 || last_bits != 16) begin bad++; $display("FAIL rd_frame: got %h/%0d want 5500/16", last_frame, last_bits); end
      total++; if (rd !== 8'h3C) begin bad++; $display("FAIL rd_rdata: got %h want 3c", rd); end
   endtask

   task automatic test_clkdiv1();
      int lat; logic [7:0] rd; logic b1, c1, s1, m1;
      sel = 1'b1;
      mem[7'h11] = 8'hFF;
      do_txn(1'b1, 7'h11, 8'h00, lat, rd, b1, c1, s1, m1);
      @(negedge clk);
      // 33*CLKDIV+1 cycles from the accept cycle to done
      total++; if (lat !== 34)   begin bad++; $display("FAIL div1_rd_latency: got %0d want 34", lat); end
      total++; if (rd !== 8'hFF) begin bad++; $display("FAIL div1_rd_rdata: got %h want ff", rd); end
      do_txn(1'b0, 7'h12, 8'h00, lat, rd, b1, c1, s1, m1);
      @(negedge clk);
      exp_rd[1] = 8'hFF;
      total++; if (lat !== 34)   begin bad++; $display("FAIL div1_wr_latency: got %0d want 34", lat); end
      total++; if (rd !== 8'hFF) begin bad++; $display("FAIL div1_wr_rdata_kept: got %h want ff", rd); end
      total++; if (last_frame !== 16'h2400) begin bad++; $display("FAIL div1_wr_frame: got %h want 2400", last_frame); end
   endtask

   task automatic test_ignored_start();
      int n, d0, f0;
      sel = 1'b0;
      d0 = done_cnt; f0 = frames;
      @(negedge clk);
      start = 1'b1; rw = 1'b0; addr = 7'h05; wdata = 8'hC3;
      @(negedge clk);
      start = 1'b0; n = 1;
      while (n < 10) begin @(negedge clk); n++; end
      start = 1'b1; rw = 1'b1; addr = 7'h7E; wdata = 8'h18;
      @(negedge clk);
      start = 1'b0;
      repeat (300) @(negedge clk);
      total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL ign_done_count: got %0d want 1", done_cnt - d0); end
      total++; if (frames - f0 != 1)   begin bad++; $display("FAIL ign_frame_count: got %0d want 1", frames - f0); end
      total++; if (last_frame !== 16'h0AC3) begin bad++; $display("FAIL ign_frame: got %h want 0ac3", last_frame); end
      total++; if (o_busy !== 1'b0 || o_cs !== 1'b1) begin bad++; $display("FAIL ign_idle busy/cs: got %b%b want 01", o_busy, o_cs); end
      total++; if (o_rdata !== exp_rd[0]) begin bad++; $display("FAIL ign_rdata: got %h want %h", o_rdata, exp_rd[0]); end
   endtask

   task automatic test_back_to_back();
      int n; logic pcs;
      logic [7:0] v;
      sel = 1'b1;
      v = 8'($urandom);
      mem[7'h4D] = v;
      @(negedge clk);
      start = 1'b1; rw = 1'b1; addr = 7'h4D; wdata = 8'h00;
      n = 0; pcs = 1'b0;
      while (o_done !== 1'b1 && n < 100) begin pcs = o_cs; @(negedge clk); n++; end
      total++; if (o_done !== 1'b1 || pcs !== 1'b0 || o_cs !== 1'b1) begin bad++; $display("FAIL b2b_first_done done/prev_cs/cs: got %b%b%b want 101", o_done, pcs, o_cs); end
      total++; if (o_rdata !== v) begin bad++; $display("FAIL b2b_rdata1: got %h want %h", o_rdata, v); end
      @(negedge clk);
      start = 1'b0;
      total++; if (o_cs !== 1'b0 || o_busy !== 1'b1) begin bad++; $display("FAIL b2b_restart cs/busy: got %b%b want 01", o_cs, o_busy); end
      n = 1;
      while (o_done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      total++; if (n !== 34) begin bad++; $display("FAIL b2b_period: got %0d want 34", n); end
      total++; if (o_rdata !== v) begin bad++; $display("FAIL b2b_rdata2: got %h want %h", o_rdata, v); end
      @(negedge clk);
      exp_rd[1] = v;
      total++; if (o_cs !== 1'b1 || o_busy !== 1'b0) begin bad++; $display("FAIL b2b_stop cs/busy: got %b%b want 10", o_cs, o_busy); end
   endtask

   task automatic test_reset_mid();
      int n, d0, lat; logic [7:0] rd, v; logic b1, c1, s1, m1;
      sel = 1'b0;
      v = 8'($urandom);
      mem[7'h33] = v;
      @(negedge clk);
      start = 1'b1; rw = 1'b1; addr = 7'h33;
      @(negedge clk);
      start = 1'b0; n = 1;
      while (n < 50) begin @(negedge clk); n++; end
      d0 = done_cnt;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      total++; if ({o_cs, o_sclk, o_busy} !== 3'b100) begin bad++; $display("FAIL rst_mid cs/sclk/busy: got %b want 100", {o_cs, o_sclk, o_busy}); end
      total++; if (o_rdata !== 8'h00) begin bad++; $display("FAIL rst_mid_rdata: got %h want 00", o_rdata); end
      repeat (150) @(negedge clk);
      total++; if (done_cnt != d0) begin bad++; $display("FAIL rst_mid_no_done: got %0d want %0d", done_cnt, d0); end
      reset = 1'b1; start = 1'b1;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      @(negedge clk);
      total++; if (o_busy !== 1'b0 || o_cs !== 1'b1) begin bad++; $display("FAIL rst_over_start busy/cs: got %b%b want 01", o_busy, o_cs); end
      do_txn(1'b1, 7'h33, 8'h00, lat, rd, b1, c1, s1, m1);
      @(negedge clk);
      exp_rd[0] = v;
      total++; if (lat !== 133) begin bad++; $display("FAIL rst_after_latency: got %0d want 133", lat); end
      total++; if (rd !== v)    begin bad++; $display("FAIL rst_after_rdata: got %h want %h", rd, v); end
   endtask

   task automatic test_random();
      int lat, cd; logic [7:0] rd, w, ev; logic [6:0] a; logic r, b1, c1, s1, m1;
      logic [15:0] ef;
      for (int i = 0; i < 16; i++) begin
         sel = 1'($urandom);
         r   = 1'($urandom);
         a   = 7'($urandom);
         w   = 8'($urandom);
         cd  = sel ? 1 : 4;
         if (r) exp_rd[sel] = mem[a];
         ev = exp_rd[sel];
         ef = {a, r, r ? 8'h00 : w};
         do_txn(r, a, w, lat, rd, b1, c1, s1, m1);
         @(negedge clk);
         total++; if (lat !== 33*cd+1) begin bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, 33*cd+1); end
         total++; if ({b1, c1, s1, m1} !== {3'b100, a[6]}) begin bad++; $display("FAIL rnd%0d_first_cycle: got %b want %b", i, {b1, c1, s1, m1}, {3'b100, a[6]}); end
         total++; if (last_frame !== ef || last_bits != 16) begin bad++; $display("FAIL rnd%0d_frame: got %h/%0d want %h/16", i, last_frame, last_bits, ef); end
         total++; if (rd !== ev) begin bad++; $display("FAIL rnd%0d_rdata: got %h want %h", i, rd, ev); end
      end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
      test_reset();
      test_write_spec();
      test_read_spec();
      test_clkdiv1();
      test_ignored_start();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
